// File: rtl/srl_fifo_pkg.sv
// -----------------------------------------------------------------------------
// srl_fifo_pkg
// Shared constants, the SRL address-width helper and the output-stage state
// type for the SRL32-based FIFO controller.
// No ports (package).
// -----------------------------------------------------------------------------
package srl_fifo_pkg;

  // Taps per SRLC32E primitive.
  localparam int SRL_LEN  = 32;
  // Largest number of SRL32s cascaded per chain (MUXF7/F8 read mux limit).
  localparam int MAX_SEGS = 4;

  // Address width of a chain built from n SRL32 segments.
  function automatic int srl_aw(input int n);
    return $clog2(SRL_LEN) + $clog2(n);
  endfunction

  // Output register state: EMPTY holds nothing, PRIMED has words in the SRLs
  // but DOUT is not yet valid, HOLD means DOUT carries a valid word.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    PRIMED = 2'b01,
    HOLD   = 2'b10
  } out_state_e;

endpackage : srl_fifo_pkg

// File: rtl/srl_fifo_occ.sv
// -----------------------------------------------------------------------------
// srl_fifo_occ
// Up/down occupancy counter for the SRL chains, with registered full/empty
// flags and a registered read address (oldest entry sits at count-1).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear to zero occupancy
//   inc          a word is shifted into the SRLs this cycle
//   dec          the oldest SRL word is moved to DOUT this cycle
//   level        words held in the SRLs, 0..D
//   rd_addr      read address of the oldest word (0 when empty)
//   full, empty  registered occupancy flags
// -----------------------------------------------------------------------------
module srl_fifo_occ
  import srl_fifo_pkg::*;
#(
  parameter int D  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          inc,
  input  logic          dec,
  output logic [AW:0]   level,
  output logic [AW-1:0] rd_addr,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   DEPTH    = (AW+1)'(D);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW-1:0] ADR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADR_ZERO = AW'(0);

  logic [AW:0]   cnt_r;
  logic [AW:0]   cnt_nxt_s;
  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_nxt_s;
  logic          full_r;
  logic          empty_r;

  // Next occupancy; simultaneous shift and read leave the count unchanged.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (flush) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (inc && !dec) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (dec && !inc) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Read address of the oldest word after this edge. At count D the low AW
  // bits are zero, so the wrapped decrement lands on D-1 as required.
  always_comb begin
    addr_nxt_s = ADR_ZERO;
    if (cnt_nxt_s != CNT_ZERO) begin
      addr_nxt_s = cnt_nxt_s[AW-1:0] - ADR_ONE;
    end else begin
      addr_nxt_s = ADR_ZERO;
    end
  end

  // Count, address and flags all update together so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= CNT_ZERO;
      addr_r  <= ADR_ZERO;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      cnt_r   <= cnt_nxt_s;
      addr_r  <= addr_nxt_s;
      full_r  <= (cnt_nxt_s == DEPTH);
      empty_r <= (cnt_nxt_s == CNT_ZERO);
    end
  end

  assign level   = cnt_r;
  assign rd_addr = addr_r;
  assign full    = full_r;
  assign empty   = empty_r;

endmodule : srl_fifo_occ

// File: rtl/srl_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// srl_fifo_ctrl
// Controller for W parallel SRL32 chains (N segments each) used as a
// first-word-fall-through FIFO. Drives shift enable and read address to the
// chains, tracks occupancy and owns the W-bit output register DOUT.
// Capacity is 32*N words in the SRLs plus one in DOUT.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of all contents
//   in_valid/in_ready   write handshake (in_ready is a registered flag)
//   srl_ce              shift enable to every chain (same cycle as handshake)
//   srl_a               read address to every chain
//   srl_q               combinational chain outputs at srl_a
//   out_valid/out_ready read handshake on DOUT
//   dout                registered oldest word
//   level               words held in the SRLs (excludes DOUT)
// -----------------------------------------------------------------------------
module srl_fifo_ctrl
  import srl_fifo_pkg::*;
#(
  parameter  int N  = 1,
  parameter  int W  = 8,
  localparam int AW = srl_aw(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          srl_ce,
  output logic [AW-1:0] srl_a,
  input  logic [W-1:0]  srl_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level
);

  localparam int D = SRL_LEN * N;

  if (N < 1 || N > MAX_SEGS) begin : g_bad_n
    $error("srl_fifo_ctrl: N must be in 1..%0d", MAX_SEGS);
  end

  out_state_e   state_r;
  out_state_e   state_nxt_s;
  logic [W-1:0] dout_r;
  logic         push_s;
  logic         load_s;
  logic         full_s;
  logic         empty_s;

  srl_fifo_occ #(
    .D  (D),
    .AW (AW)
  ) u_occ (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .inc     (push_s),
    .dec     (load_s),
    .level   (level),
    .rd_addr (srl_a),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Write and refill conditions; flush suppresses both for its cycle.
  always_comb begin
    push_s = in_valid && !full_s && !flush;
    load_s = !flush && !empty_s && ((state_r != HOLD) || out_ready);
  end

  // Output-stage next state.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            state_nxt_s = PRIMED;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        PRIMED: begin
          if (load_s) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = PRIMED;
          end
        end
        HOLD: begin
          // Without a refill, a consumed DOUT means the SRLs were empty; a
          // same-cycle push leaves one word waiting for the next load.
          if (load_s) begin
            state_nxt_s = HOLD;
          end else if (out_ready) begin
            state_nxt_s = push_s ? PRIMED : EMPTY;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
        end
      endcase
    end
  end

  // Output state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // DOUT captures the oldest SRL word on refill and otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= {W{1'b0}};
    end else if (load_s) begin
      dout_r <= srl_q;
    end else begin
      dout_r <= dout_r;
    end
  end

  assign srl_ce    = push_s;
  assign in_ready  = !full_s;
  assign out_valid = (state_r == HOLD);
  assign dout      = dout_r;

endmodule : srl_fifo_ctrl
